// File: rtl/tcp_pkg.sv
// Shared TCP offload definitions: flow index width and per-flow state entry layouts.
package tcp_pkg;

  localparam int unsigned FLOWID_W = 4;

  typedef struct packed {
    logic [31:0] snd_nxt;
    logic [31:0] snd_una;
  } tx_state_struct;

  typedef struct packed {
    logic [31:0] rcv_nxt;
    logic [15:0] rcv_wnd;
    logic [15:0] flags;
  } recv_state_entry;

endpackage

// File: rtl/flow_state_ram.sv
// Simple dual-port state RAM: one write port, one registered read port, no reset on storage.
module flow_state_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write contents on an address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/flow_state_rd_server.sv
// Per-flow state store: zeroing sweep after reset, then in-order reads with a
// 2-entry response queue and write-first bypass for same-cycle collisions.
module flow_state_rd_server
  import tcp_pkg::*;
#(
  parameter int unsigned DATA_W   = $bits(tx_state_struct),
  parameter int unsigned FLOWID_W = tcp_pkg::FLOWID_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_req_val,
  input  logic [FLOWID_W-1:0] rd_req_flowid,
  output logic                rd_req_rdy,
  output logic                rd_resp_val,
  output logic [DATA_W-1:0]   rd_resp_data,
  input  logic                rd_resp_rdy,
  input  logic                wr_req_val,
  input  logic [FLOWID_W-1:0] wr_req_flowid,
  input  logic [DATA_W-1:0]   wr_req_data,
  output logic                wr_req_rdy,
  output logic                init_done
);

  localparam int unsigned DEPTH = 1 << FLOWID_W;
  localparam int unsigned CNT_W = FLOWID_W + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    init_cnt_q, init_cnt_d;
  logic [1:0]          q_cnt_q, q_cnt_d;
  logic                head_q, head_d, tail_q, tail_d;
  logic [DATA_W-1:0]   q_data_q [2];
  logic [DATA_W-1:0]   q_data_d [2];
  logic                inflight_q, inflight_d;
  logic                byp_q, byp_d;
  logic [DATA_W-1:0]   byp_data_q, byp_data_d;
  logic                rd_req_rdy_q, rd_req_rdy_d;
  logic                wr_req_rdy_q, wr_req_rdy_d;
  logic                init_done_q, init_done_d;

  logic                rd_fire, wr_fire, push, pop, q_empty;
  logic                ram_we;
  logic [FLOWID_W-1:0] ram_waddr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata, arr_data;

  flow_state_ram #(.DATA_W(DATA_W), .ADDR_W(FLOWID_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_fire),
    .raddr (rd_req_flowid),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_fire  = rd_req_val & rd_req_rdy_q;
    wr_fire  = wr_req_val & wr_req_rdy_q;
    q_empty  = (q_cnt_q == 2'd0);
    arr_data = byp_q ? byp_data_q : ram_rdata;
    pop      = ~q_empty & rd_resp_rdy;
    // Arriving data bypasses the queue only when the queue is empty and the consumer takes it now.
    push     = inflight_q & ~(q_empty & rd_resp_rdy);

    ram_we    = (state_q == ST_INIT) | wr_fire;
    ram_waddr = (state_q == ST_INIT) ? init_cnt_q[FLOWID_W-1:0] : wr_req_flowid;
    ram_wdata = (state_q == ST_INIT) ? '0 : wr_req_data;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    q_cnt_d    = q_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    q_data_d   = q_data_q;
    inflight_d = rd_fire;
    byp_d      = rd_fire & wr_fire & (rd_req_flowid == wr_req_flowid);
    byp_data_d = wr_req_data;

    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + CNT_W'(1);
        if (init_cnt_q == CNT_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase

    if (push) begin
      q_data_d[tail_q] = arr_data;
      tail_d           = ~tail_q;
    end
    if (pop) head_d = ~head_q;
    q_cnt_d = q_cnt_q + 2'(push) - 2'(pop);

    // Credit: queue occupancy plus the read already in the RAM pipe must leave room for one more.
    rd_req_rdy_d = (state_d == ST_RUN) &&
                   ((3'(q_cnt_d) + 3'(inflight_d)) < 3'd2);
    wr_req_rdy_d = (state_d == ST_RUN);
    init_done_d  = init_done_q | (state_q == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      q_cnt_q      <= '0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      q_data_q     <= '{default: '0};
      inflight_q   <= 1'b0;
      byp_q        <= 1'b0;
      byp_data_q   <= '0;
      rd_req_rdy_q <= 1'b0;
      wr_req_rdy_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      q_cnt_q      <= q_cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      q_data_q     <= q_data_d;
      inflight_q   <= inflight_d;
      byp_q        <= byp_d;
      byp_data_q   <= byp_data_d;
      rd_req_rdy_q <= rd_req_rdy_d;
      wr_req_rdy_q <= wr_req_rdy_d;
      init_done_q  <= init_done_d;
    end
  end

  assign rd_req_rdy   = rd_req_rdy_q;
  assign wr_req_rdy   = wr_req_rdy_q;
  assign init_done    = init_done_q;
  assign rd_resp_val  = ~q_empty | inflight_q;
  assign rd_resp_data = ~q_empty ? q_data_q[head_q] : (inflight_q ? arr_data : '0);

endmodule

// File: tb/tb_flow_state_rd_server.sv
// Self-checking bench for flow_state_rd_server: init sweep, streaming, backpressure,
// write/read collisions and mid-operation reset, with a response scoreboard.
module tb_flow_state_rd_server;

  localparam int unsigned FW = 4;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req_val = 1'b0;
  logic [FW-1:0] rd_req_flowid = '0;
  logic          rd_req_rdy;
  logic          rd_resp_val;
  logic [DW-1:0] rd_resp_data;
  logic          rd_resp_rdy = 1'b1;
  logic          wr_req_val = 1'b0;
  logic [FW-1:0] wr_req_flowid = '0;
  logic [DW-1:0] wr_req_data = '0;
  logic          wr_req_rdy;
  logic          init_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] model_mem [16];

  flow_state_rd_server #(.DATA_W(DW), .FLOWID_W(FW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_req_val    (rd_req_val),
    .rd_req_flowid (rd_req_flowid),
    .rd_req_rdy    (rd_req_rdy),
    .rd_resp_val   (rd_resp_val),
    .rd_resp_data  (rd_resp_data),
    .rd_resp_rdy   (rd_resp_rdy),
    .wr_req_val    (wr_req_val),
    .wr_req_flowid (wr_req_flowid),
    .wr_req_data   (wr_req_data),
    .wr_req_rdy    (wr_req_rdy),
    .init_done     (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model and scoreboard: write applied before read lookup gives write-first semantics.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
    end else begin
      if (wr_req_val && wr_req_rdy) model_mem[wr_req_flowid] = wr_req_data;
      if (rd_req_val && rd_req_rdy) sb_q.push_back(model_mem[rd_req_flowid]);
      if (rd_resp_val && rd_resp_rdy) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got %h expected no response", rd_resp_data);
        end else begin
          logic [DW-1:0] exp;
          exp = sb_q.pop_front();
          if (rd_resp_data !== exp) begin
            n_fail++;
            $display("FAIL resp_data: got %h expected %h", rd_resp_data, exp);
          end
        end
      end
    end
  end

  typedef struct {
    logic          wr_val;
    logic [FW-1:0] wr_flow;
    logic [DW-1:0] wr_data;
    logic          rd_val;
    logic [FW-1:0] rd_flow;
    logic          resp_rdy;
    logic          exp_rdy;
    logic          exp_val;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [13];

  task automatic apply_vec(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    wr_req_val    = v.wr_val;
    wr_req_flowid = v.wr_flow;
    wr_req_data   = v.wr_data;
    rd_req_val    = v.rd_val;
    rd_req_flowid = v.rd_flow;
    rd_resp_rdy   = v.resp_rdy;
    @(negedge clk);
    chk($sformatf("vec%0d_rd_req_rdy", idx), DW'(rd_req_rdy), DW'(v.exp_rdy));
    chk($sformatf("vec%0d_rd_resp_val", idx), DW'(rd_resp_val), DW'(v.exp_val));
    if (v.exp_val) chk($sformatf("vec%0d_rd_resp_data", idx), rd_resp_data, v.exp_data);
  endtask

  // Reset, check reset values, release with a read of `flow` held, and time the sweep.
  task automatic reset_and_sweep(input logic [FW-1:0] flow);
    rst_n = 1'b0;
    rd_req_val = 1'b0;
    wr_req_val = 1'b0;
    rd_resp_rdy = 1'b1;
    #1;
    chk("rst_rd_resp_val", DW'(rd_resp_val), '0);
    chk("rst_rd_resp_data", rd_resp_data, '0);
    chk("rst_rd_req_rdy", DW'(rd_req_rdy), '0);
    chk("rst_wr_req_rdy", DW'(wr_req_rdy), '0);
    chk("rst_init_done", DW'(init_done), '0);
    repeat (2) @(negedge clk);
    rd_req_val    = 1'b1;
    rd_req_flowid = flow;
    rst_n         = 1'b1;
    chk("sweep_cycle0_rdy", DW'(rd_req_rdy), '0);
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sweep_cycle%0d_rd_req_rdy", e), DW'(rd_req_rdy), DW'(e == 16));
      chk($sformatf("sweep_cycle%0d_wr_req_rdy", e), DW'(wr_req_rdy), DW'(e == 16));
      chk($sformatf("sweep_cycle%0d_init_done", e), DW'(init_done), '0);
    end
    @(posedge clk);
    #1;
    chk("sweep_cycle17_init_done", DW'(init_done), 64'd1);
    chk("sweep_first_resp_val", DW'(rd_resp_val), 64'd1);
    chk("sweep_first_resp_data", rd_resp_data, '0);
    rd_req_val = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Backpressure: reads 1,2,3 with consumer stalled for 5 cycles.
    vecs[0]  = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 64'h101};
    vecs[2]  = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 64'h101};
    vecs[3]  = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 64'h101};
    vecs[4]  = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 64'h101};
    vecs[5]  = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 64'h101};
    vecs[6]  = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 64'h102};
    vecs[7]  = '{1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 64'h103};
    vecs[8]  = '{1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 64'h0};
    // Collisions on flow 5: same-cycle write-first, then next-cycle write not visible.
    vecs[9]  = '{1'b1, 4'd5, 64'hDEAD, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 64'h0};
    vecs[10] = '{1'b1, 4'd5, 64'hBEEF, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 64'hDEAD};
    vecs[11] = '{1'b0, 4'd0, 64'h0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 64'h0};
    vecs[12] = '{1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 64'hBEEF};

    reset_and_sweep(4'd3);

    // Streaming: fill every flow, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      wr_req_val    = 1'b1;
      wr_req_flowid = FW'(i);
      wr_req_data   = 64'h100 + DW'(i);
    end
    @(posedge clk);
    #1;
    wr_req_val = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      rd_req_val    = (i < 16);
      rd_req_flowid = FW'(i);
      @(negedge clk);
      if (i < 16) chk($sformatf("stream%0d_rd_req_rdy", i), DW'(rd_req_rdy), 64'd1);
      if (i > 0)  chk($sformatf("stream%0d_rd_resp_val", i), DW'(rd_resp_val), 64'd1);
    end

    for (int i = 0; i < 13; i++) apply_vec(vecs[i], i);

    // Mid-operation reset with the queue full.
    for (int i = 0; i < 4; i++) apply_vec(vecs[i], 100 + i);
    #2;
    reset_and_sweep(4'd5);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", DW'(sb_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
